// File: rtl/gf16_mul_engine.sv
// Time-multiplexed GF(2^4) nibble multiplier: 16 nibble products (d1*d2 or d1*LAMBDA), LANES per cycle.
// Optional completed-transaction counter enabled with `define GF16_MUL_ENGINE_PERF_EN.
module gf16_mul_engine #(
  parameter int         LANES  = 4,
  parameter logic [3:0] POLY   = 4'b0011,
  parameter logic [3:0] LAMBDA = 4'hC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [63:0] req_d1,
  input  logic [63:0] req_d2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data
`ifdef GF16_MUL_ENGINE_PERF_EN
  ,
  output logic [15:0] txn_count
`endif
);

  localparam int STEPS = 16 / LANES;
  localparam int IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             op_p0;
  logic [63:0]      d1_p0, d2_p0;
  logic [63:0]      result_p1;
  logic [3:0]       nib_sel [LANES];
  logic [3:0]       prod    [LANES];

  // Carry-less 4x4 product, then fold bits 6..4 back down using x^4 = POLY.
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 4; i++)
      if (b[i]) p = p ^ (7'(a) << i);
    for (int i = 6; i >= 4; i--)
      if (p[i]) p = p ^ (7'(POLY) << (i - 4)) ^ (7'd1 << i);
    return p[3:0];
  endfunction

  assign accept = (state == IDLE) && req_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid)       state_nxt = BUSY;
      BUSY:    if (idx == IDX_LAST) state_nxt = DONE;
      DONE:    if (rsp_ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst)               idx <= '0;
    else if (accept)       idx <= '0;
    else if (state == BUSY) idx <= idx + IDX_W'(1);
  end

  // Stage p0: operand capture at acceptance; later request activity cannot reach the in-flight job.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0 <= req_op;
      d1_p0 <= req_d1;
      d2_p0 <= req_op ? 64'd0 : req_d2;
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      nib_sel[l] = 4'(int'(idx) * LANES + l);
      prod[l]    = gf_mul(d1_p0[{nib_sel[l], 2'b00} +: 4],
                          op_p0 ? LAMBDA : d2_p0[{nib_sel[l], 2'b00} +: 4]);
    end
  end

  // Stage p1: result register, filled LANES nibbles per BUSY cycle; unfilled nibbles stay 0.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      result_p1 <= '0;
    end else if (state == BUSY) begin
      for (int l = 0; l < LANES; l++)
        result_p1[{nib_sel[l], 2'b00} +: 4] <= prod[l];
    end
  end

  assign rsp_data = result_p1;

`ifdef GF16_MUL_ENGINE_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst)                         txn_count <= '0;
    else if (rsp_valid && rsp_ready) txn_count <= sat_inc(txn_count);
  end
`endif

endmodule

// File: tb/tb_gf16_mul_engine.sv
// Directed bench for gf16_mul_engine: hand-computed vectors plus a 256-pair sweep over LANES 1/4/16.
module tb_gf16_mul_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_op = 1'b0;
  logic [63:0] req_d1 = '0;
  logic [63:0] req_d2 = '0;
  logic        rsp_ready = 1'b0;

  logic        req_ready_l4, rsp_valid_l4;
  logic [63:0] rsp_data_l4;
  logic        req_ready_l1, rsp_valid_l1;
  logic [63:0] rsp_data_l1;
  logic        req_ready_l16, rsp_valid_l16;
  logic [63:0] rsp_data_l16;
`ifdef GF16_MUL_ENGINE_PERF_EN
  logic [15:0] txn_l4, txn_l1, txn_l16;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  gf16_mul_engine #(.LANES(4)) u_l4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_l4),
    .req_op(req_op), .req_d1(req_d1), .req_d2(req_d2),
    .rsp_valid(rsp_valid_l4), .rsp_ready(rsp_ready), .rsp_data(rsp_data_l4)
`ifdef GF16_MUL_ENGINE_PERF_EN
    , .txn_count(txn_l4)
`endif
  );

  gf16_mul_engine #(.LANES(1)) u_l1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_l1),
    .req_op(req_op), .req_d1(req_d1), .req_d2(req_d2),
    .rsp_valid(rsp_valid_l1), .rsp_ready(rsp_ready), .rsp_data(rsp_data_l1)
`ifdef GF16_MUL_ENGINE_PERF_EN
    , .txn_count(txn_l1)
`endif
  );

  gf16_mul_engine #(.LANES(16)) u_l16 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_l16),
    .req_op(req_op), .req_d1(req_d1), .req_d2(req_d2),
    .rsp_valid(rsp_valid_l16), .rsp_ready(rsp_ready), .rsp_data(rsp_data_l16)
`ifdef GF16_MUL_ENGINE_PERF_EN
    , .txn_count(txn_l16)
`endif
  );

  // Reference: shift-and-add with a per-step xtime, independent of the carry-less-then-reduce form.
  function automatic logic [3:0] xtime(input logic [3:0] v);
    return {v[2:0], 1'b0} ^ (v[3] ? 4'b0011 : 4'b0000);
  endfunction

  function automatic logic [3:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    r = '0;
    for (int i = 3; i >= 0; i--) begin
      r = xtime(r);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  function automatic logic [63:0] ref_vec(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    for (int n = 0; n < 16; n++) r[4*n +: 4] = ref_mul(a[4*n +: 4], b[4*n +: 4]);
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp4(output int lat);
    lat = 0;
    while (!rsp_valid_l4 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic [63:0] got1, got4, got16;
    logic        have1, have4, have16;
    logic [63:0] exp_v;

    // Reset, then idle
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_req_ready", req_ready_l4, 1);
    chk("reset_rsp_valid", rsp_valid_l4, 0);
    chk("reset_rsp_data", rsp_data_l4, 0);
`ifdef GF16_MUL_ENGINE_PERF_EN
    chk("reset_txn", txn_l4, 0);
`endif

    // op=0 known products, cycle-exact latency
    rsp_ready = 1'b1;
    req_op = 1'b0;
    req_d1 = 64'hF8F8_F8F8_F8F8_F8F2;
    req_d2 = 64'hF2F2_F2F2_F2F2_F2F2;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("op0_busy_ready", req_ready_l4, 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("op0_valid_c%0d", k), rsp_valid_l4, (k == 4) ? 1 : 0);
      if (k == 1) chk("op0_partial", rsp_data_l4, 64'h0000_0000_0000_A3A4);
    end
    chk("op0_data", rsp_data_l4, 64'hA3A3_A3A3_A3A3_A3A4);
    tick();
    chk("op0_hs_valid", rsp_valid_l4, 0);
    chk("op0_hs_ready", req_ready_l4, 1);

    // op=1 constant path, d2 must not matter
    req_op = 1'b1;
    req_d1 = 64'h1111_1111_1111_1212;
    req_d2 = {$urandom, $urandom};
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    wait_rsp4(lat);
    chk("op1_latency", 64'(lat), 4);
    chk("op1_data", rsp_data_l4, 64'hCCCC_CCCC_CCCC_CBCB);
    tick();

    // Backpressure with toggling request inputs
    rsp_ready = 1'b0;
    req_op = 1'b0;
    req_d1 = 64'hF8F8_F8F8_F8F8_F8F2;
    req_d2 = 64'hF2F2_F2F2_F2F2_F2F2;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    wait_rsp4(lat);
    chk("bp_latency", 64'(lat), 4);
    for (int i = 0; i < 10; i++) begin
      req_d1 = ~req_d1;
      req_op = i[0];
      req_valid = i[0];
      tick();
      chk($sformatf("bp_valid_%0d", i), rsp_valid_l4, 1);
      chk($sformatf("bp_data_%0d", i), rsp_data_l4, 64'hA3A3_A3A3_A3A3_A3A4);
      chk($sformatf("bp_ready_%0d", i), req_ready_l4, 0);
    end
    req_valid = 1'b0;
    req_op = 1'b0;
    rsp_ready = 1'b1;
    tick();
    chk("bp_release_valid", rsp_valid_l4, 0);
    chk("bp_release_ready", req_ready_l4, 1);
`ifdef GF16_MUL_ENGINE_PERF_EN
    chk("txn_after_3", txn_l4, 3);
`endif

    // Reset while BUSY at idx=2
    req_d1 = 64'h0123_4567_89AB_CDEF;
    req_d2 = 64'hFEDC_BA98_7654_3210;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ready", req_ready_l4, 1);
    chk("midrst_valid", rsp_valid_l4, 0);
    chk("midrst_data", rsp_data_l4, 0);
`ifdef GF16_MUL_ENGINE_PERF_EN
    chk("midrst_txn", txn_l4, 0);
`endif
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("midrst_quiet_%0d", i), rsp_valid_l4, 0);
    end

    // Sweep all 256 nibble pairs: transaction a puts a in every d1 nibble and i in d2 nibble i
    for (int a = 0; a < 16; a++) begin
      req_op = 1'b0;
      for (int n = 0; n < 16; n++) begin
        req_d1[4*n +: 4] = 4'(a);
        req_d2[4*n +: 4] = 4'(n);
      end
      exp_v = ref_vec(req_d1, req_d2);
      have1 = 1'b0; have4 = 1'b0; have16 = 1'b0;
      got1 = '0; got4 = '0; got16 = '0;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (rsp_valid_l1  && !have1)  begin got1  = rsp_data_l1;  have1  = 1'b1; end
        if (rsp_valid_l4  && !have4)  begin got4  = rsp_data_l4;  have4  = 1'b1; end
        if (rsp_valid_l16 && !have16) begin got16 = rsp_data_l16; have16 = 1'b1; end
        tick();
      end
      chk($sformatf("sweep_l1_seen_a%0d", a), have1, 1);
      chk($sformatf("sweep_l4_seen_a%0d", a), have4, 1);
      chk($sformatf("sweep_l16_seen_a%0d", a), have16, 1);
      chk($sformatf("sweep_l1_a%0d", a), got1, exp_v);
      chk($sformatf("sweep_l4_a%0d", a), got4, exp_v);
      chk($sformatf("sweep_l16_a%0d", a), got16, exp_v);
    end
`ifdef GF16_MUL_ENGINE_PERF_EN
    chk("txn_sweep_l4", txn_l4, 16);
    chk("txn_sweep_l1", txn_l1, 16);
    chk("txn_sweep_l16", txn_l16, 16);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
